// File: rtl/aes_feeder_pkg.sv
// aes_feeder_pkg: shared types and constants for the AES block feeder.
// Holds the FSM state encoding, bus widths and the default pipeline latency.
package aes_feeder_pkg;

  localparam int BLOCK_W     = 128;
  localparam int WORD_W      = 32;
  localparam int DEF_LATENCY = 20;

  typedef enum logic [1:0] {
    FILL,
    DRAIN,
    KEYSET
  } state_t;

endpackage

// File: rtl/aes_tag_delay.sv
// aes_tag_delay: DEPTH-stage valid+data shift line; only the valids reset.
// Ports: clk, rst, in_valid/in_data (stage 0), out_valid/out_data (last stage).
module aes_tag_delay #(
  parameter int DEPTH = 20,
  parameter int W     = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0] vld;
  logic [W-1:0]     dat [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) vld[i] <= vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    dat[0] <= in_data;
    for (int i = 1; i < DEPTH; i++) dat[i] <= dat[i-1];
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/aes_block_feeder.sv
// aes_block_feeder: packs 32-bit words into 128-bit blocks for an AES loopback
// pipeline, checks returned blocks against delayed tags, sequences key changes.
// Ports: Clk/Rst; Word_In/Word_Valid/Word_Ready; Key_In/Key_Valid/Key_Ready;
// Block_Out/Key_Out to the pipeline, Ret_Text back from it; Issue,
// Check_Valid/Check_Ok, Err_Count and In_Flight status outputs.
module aes_block_feeder
  import aes_feeder_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int ERR_W   = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [WORD_W-1:0]  Word_In,
  input  logic               Word_Valid,
  output logic               Word_Ready,
  input  logic [BLOCK_W-1:0] Key_In,
  input  logic               Key_Valid,
  output logic               Key_Ready,
  output logic [BLOCK_W-1:0] Block_Out,
  output logic [BLOCK_W-1:0] Key_Out,
  input  logic [BLOCK_W-1:0] Ret_Text,
  output logic               Issue,
  output logic               Check_Valid,
  output logic               Check_Ok,
  output logic [ERR_W-1:0]   Err_Count,
  output logic [4:0]         In_Flight
);

  state_t                  state;
  logic [1:0]              cnt;
  logic [3*WORD_W-1:0]     hold;
  logic                    key_go;
  logic                    take;
  logic                    last;
  logic                    tag_valid;
  logic [BLOCK_W-1:0]      tag_data;
  logic                    bad;

  // A key request at a block boundary wins over a word offered
  // in the same cycle, so Word_Ready drops to refuse that word.
  assign key_go     = (state == FILL) && Key_Valid && (cnt == 2'd0);
  assign Word_Ready = !Rst && (state == FILL) && !key_go;
  assign Key_Ready  = !Rst && (state == KEYSET);
  assign take       = Word_Valid && Word_Ready;
  assign last       = take && (cnt == 2'd3);
  assign bad        = tag_valid && (Ret_Text != tag_data);

  aes_tag_delay #(
    .DEPTH (LATENCY),
    .W     (BLOCK_W)
  ) u_delay (
    .clk       (Clk),
    .rst       (Rst),
    .in_valid  (last),
    .in_data   ({hold, Word_In}),
    .out_valid (tag_valid),
    .out_data  (tag_data)
  );

  // First three words of a block; oldest ends up in the top slot.
  always_ff @(posedge Clk) begin
    if (take) hold <= {hold[2*WORD_W-1:0], Word_In};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= FILL;
      cnt         <= 2'd0;
      Block_Out   <= '0;
      Key_Out     <= '0;
      Issue       <= 1'b0;
      Check_Valid <= 1'b0;
      Check_Ok    <= 1'b0;
      Err_Count   <= '0;
      In_Flight   <= 5'd0;
    end else begin
      Issue       <= last;
      Check_Valid <= tag_valid;
      Check_Ok    <= tag_valid && !bad;
      if (bad && (Err_Count != '1))
        Err_Count <= Err_Count + ERR_W'(1);
      if (last && !tag_valid)
        In_Flight <= In_Flight + 5'd1;
      else if (!last && tag_valid)
        In_Flight <= In_Flight - 5'd1;
      if (take) cnt <= cnt + 2'd1;
      if (last) Block_Out <= {hold, Word_In};
      unique case (state)
        FILL: begin
          if (key_go) state <= DRAIN;
        end
        DRAIN: begin
          if (!Key_Valid)
            state <= FILL;
          else if ((In_Flight == 5'd0) && !Issue)
            state <= KEYSET;
        end
        KEYSET: begin
          Key_Out <= Key_In;
          state   <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
